jt1943_objdma: RTL and testbench



---
 rtl/jt1943_obj_defs.sv | 23 ++
 rtl/jt1943_objdma_cnt.sv | 45 ++++
 rtl/jt1943_objdma.sv | 218 +++++++++++++++++++++
 tb/tb_jt1943_objdma.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_obj_defs.sv
// Shared definitions for the 1943 object-RAM DMA: state encoding, default
// copy window and counter/buffer widths.
package jt1943_obj_defs;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_PRIME = 3'd2;
   localparam logic [2:0] S_COPY  = 3'd3;
   localparam logic [2:0] S_REL   = 3'd4;

   localparam logic [12:0] OBJ_BASE_DEF = 13'h1000;
   localparam int          OBJ_LEN_DEF  = 512;

   localparam int BUF_AW = 9;
   localparam int CNT_W  = 10;

   // Object-RAM address for a copy offset; wraps modulo 8192.
   function automatic logic [12:0] obj_addr(input logic [12:0] base,
                                            input logic [CNT_W-1:0] ofs);
      return base + {3'b000, ofs};
   endfunction

endpackage

// File: rtl/jt1943_objdma_cnt.sv
// Loadable up-counter advanced on cen, with a terminal-count flag that is
// high while the count equals LAST.
module jt1943_objdma_cnt
   import jt1943_obj_defs::*;
#(
   parameter logic [CNT_W-1:0] LAST = 10'd0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             cen_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] q_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load has priority over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + 10'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 10'd0;
      end else if (cen_i) begin
         cnt_q <= cnt_d;
      end
   end

   assign q_o  = cnt_q;
   assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/jt1943_objdma.sv
// Once-per-frame object-RAM DMA: takes the CPU bus at vertical blank via
// BUSRQ/BUSAK, streams the sprite table into the object line buffer, releases.
module jt1943_objdma
   import jt1943_obj_defs::*;
#(
   parameter logic [12:0] OBJ_BASE = OBJ_BASE_DEF,
   parameter int          OBJ_LEN  = OBJ_LEN_DEF,
   parameter int          ACK_TO   = 63
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              LVBL,
   output logic              bus_req,
   input  logic              bus_ack,
   output logic              blcnten,
   output logic [12:0]       obj_AB,
   input  logic [7:0]        ram_dout,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [7:0]        buf_data,
   output logic              buf_we,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [CNT_W-1:0] LEN_LAST = 10'(OBJ_LEN);
   localparam logic [CNT_W-1:0] TO_LAST  = 10'(ACK_TO - 1);

   logic [2:0]        state_q, state_d;
   logic              lvbl_q, arm_q;
   logic              bus_req_q, bus_req_d;
   logic              en_q, en_d;
   logic [12:0]       obj_ab_q, obj_ab_d;
   logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              trig;
   logic              rel_go;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt, cnt_ld_val;
   logic              cnt_ld, cnt_inc, cnt_tc;
   logic              to_ld, to_inc, to_tc;
   logic [CNT_W-1:0]  to_q_unused;

   jt1943_objdma_cnt #(.LAST(LEN_LAST)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .cen_i      (cen),
      .load_i     (cnt_ld),
      .load_val_i (cnt_ld_val),
      .inc_i      (cnt_inc),
      .q_o        (cnt_q),
      .tc_o       (cnt_tc)
   );

   jt1943_objdma_cnt #(.LAST(TO_LAST)) u_tocnt (
      .clk        (clk),
      .rst        (rst),
      .cen_i      (cen),
      .load_i     (to_ld),
      .load_val_i (10'd0),
      .inc_i      (to_inc),
      .q_o        (to_q_unused),
      .tc_o       (to_tc)
   );

   assign cnt_nxt = cnt_q + 10'd1;

   // Next-state and next-output logic; outputs are registered alongside the state.
   always_comb begin
      trig       = arm_q & lvbl_q & ~LVBL;
      state_d    = state_q;
      bus_req_d  = bus_req_q;
      en_d       = en_q;
      obj_ab_d   = obj_ab_q;
      buf_addr_d = buf_addr_q;
      we_d       = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cnt_ld     = 1'b0;
      cnt_ld_val = 10'd0;
      cnt_inc    = 1'b0;
      to_ld      = 1'b0;
      to_inc     = 1'b0;
      rel_go     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d   = S_REQ;
               bus_req_d = 1'b1;
               busy_d    = 1'b1;
               cnt_ld    = 1'b1;
               to_ld     = 1'b1;
            end else begin
               bus_req_d  = 1'b0;
               en_d       = 1'b0;
               obj_ab_d   = 13'h0000;
               buf_addr_d = 9'd0;
               busy_d     = 1'b0;
            end
         end
         S_REQ: begin
            if (bus_ack) begin
               state_d  = S_PRIME;
               en_d     = 1'b1;
               obj_ab_d = OBJ_BASE;
            end else if (to_tc) begin
               state_d   = S_IDLE;
               bus_req_d = 1'b0;
               busy_d    = 1'b0;
               err_d     = 1'b1;
            end else begin
               to_inc = 1'b1;
            end
         end
         S_PRIME: begin
            if (!bus_ack) begin
               rel_go = 1'b1;
               err_d  = 1'b1;
            end else begin
               state_d    = S_COPY;
               cnt_ld     = 1'b1;
               cnt_ld_val = 10'd1;
               obj_ab_d   = obj_addr(OBJ_BASE, 10'd1);
               buf_addr_d = 9'd0;
               we_d       = 1'b1;
            end
         end
         S_COPY: begin
            // Data for OBJ_BASE+cnt-1 arrives a cen after its address was presented.
            if (!bus_ack) begin
               rel_go = 1'b1;
               err_d  = 1'b1;
            end else if (cnt_tc) begin
               rel_go = 1'b1;
               done_d = 1'b1;
            end else begin
               cnt_inc    = 1'b1;
               obj_ab_d   = obj_addr(OBJ_BASE, cnt_nxt);
               buf_addr_d = cnt_q[BUF_AW-1:0];
               we_d       = 1'b1;
            end
         end
         S_REL: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
            en_d      = 1'b0;
            busy_d    = 1'b0;
         end
         default: begin
            state_d    = S_IDLE;
            bus_req_d  = 1'b0;
            en_d       = 1'b0;
            obj_ab_d   = 13'h0000;
            buf_addr_d = 9'd0;
            busy_d     = 1'b0;
         end
      endcase

      if (rel_go) begin
         state_d    = S_REL;
         bus_req_d  = 1'b0;
         en_d       = 1'b0;
         obj_ab_d   = 13'h0000;
         buf_addr_d = 9'd0;
         we_d       = 1'b0;
         busy_d     = 1'b1;
      end else begin
         state_d = state_d;
      end
   end

   // State, registered outputs and LVBL edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lvbl_q     <= 1'b1;
         arm_q      <= 1'b0;
         bus_req_q  <= 1'b0;
         en_q       <= 1'b0;
         obj_ab_q   <= 13'h0000;
         buf_addr_q <= 9'd0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else if (cen) begin
         state_q    <= state_d;
         lvbl_q     <= LVBL;
         arm_q      <= 1'b1;
         bus_req_q  <= bus_req_d;
         en_q       <= en_d;
         obj_ab_q   <= obj_ab_d;
         buf_addr_q <= buf_addr_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // A dropped ack must release the RAM port and cancel the pending write at once.
   assign blcnten  = en_q & bus_ack;
   assign buf_we   = we_q & bus_ack;
   assign buf_data = ram_dout & {8{we_q}};
   assign bus_req  = bus_req_q;
   assign obj_AB   = obj_ab_q;
   assign buf_addr = buf_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_jt1943_objdma.sv
// Scoreboard bench for jt1943_objdma: a CPU bus-ack model and registered RAM
// model drive the DUT; expected line-buffer writes are queued and popped.
module tb_jt1943_objdma;

   logic        clk = 1'b0, rst = 1'b1, cen = 1'b0, lvbl = 1'b1, bus_ack = 1'b0;
   logic [7:0]  ram_dout = 8'h00;
   logic        bus_req, blcnten, buf_we, busy, done, err;
   logic [12:0] obj_ab;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_data;

   logic        lvbl_w = 1'b1, ack_w = 1'b0;
   logic [7:0]  ram_w = 8'h00;
   logic        bus_req_w, blcnten_w, buf_we_w, busy_w, done_w, err_w;
   logic [12:0] obj_ab_w;
   logic [8:0]  buf_addr_w;
   logic [7:0]  buf_data_w;

   jt1943_objdma u_dut (
      .clk(clk), .rst(rst), .cen(cen), .LVBL(lvbl), .bus_req(bus_req), .bus_ack(bus_ack),
      .blcnten(blcnten), .obj_AB(obj_ab), .ram_dout(ram_dout), .buf_addr(buf_addr),
      .buf_data(buf_data), .buf_we(buf_we), .busy(busy), .done(done), .err(err)
   );

   jt1943_objdma #(.OBJ_BASE(13'h1FFE), .OBJ_LEN(4)) u_wrap (
      .clk(clk), .rst(rst), .cen(cen), .LVBL(lvbl_w), .bus_req(bus_req_w), .bus_ack(ack_w),
      .blcnten(blcnten_w), .obj_AB(obj_ab_w), .ram_dout(ram_w), .buf_addr(buf_addr_w),
      .buf_data(buf_data_w), .buf_we(buf_we_w), .busy(busy_w), .done(done_w), .err(err_w)
   );

   logic [35:0] outs, outs_w;
   assign outs   = {bus_req, blcnten, obj_ab, buf_addr, buf_data, buf_we, busy, done, err};
   assign outs_w = {bus_req_w, blcnten_w, obj_ab_w, buf_addr_w, buf_data_w, buf_we_w,
                    busy_w, done_w, err_w};

   int n_checks = 0, n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ram_f(input logic [12:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   logic [16:0] sb_q[$];
   logic [16:0] sbw_q[$];
   logic [12:0] abw_q[$];

   int   wr_cnt, en_cnt, req_cnt, done_cnt, err_cnt, req_rise, last_addr, first_addr;
   int   wr_w_cnt, en_w_cnt, done_w_cnt;
   logic req_prev = 1'b0;
   logic [16:0] exp_v, exp_w;
   logic [12:0] exp_ab;

   bit   ack_hold = 1'b0, killed = 1'b0, was_cen;
   int   kill_addr = -1, ack_cnt = 0;

   task automatic reset_counts();
      wr_cnt = 0; en_cnt = 0; req_cnt = 0; done_cnt = 0; err_cnt = 0;
      req_rise = 0; last_addr = -1; first_addr = -1;
      wr_w_cnt = 0; en_w_cnt = 0; done_w_cnt = 0;
   endtask

   task automatic step_cen(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (cen !== 1'b1);
      end
      #2;
   endtask

   initial forever #5 clk = ~clk;

   // cen every other clk; CPU acknowledges 3 cen after a request, or never, or drops it at kill_addr
   initial begin
      forever begin
         @(posedge clk);
         #1;
         was_cen = cen;
         cen = ~cen;
         if (was_cen) begin
            if (!bus_req) begin
               bus_ack = 1'b0;
               ack_cnt = 0;
            end else if (ack_hold || killed) begin
               bus_ack = 1'b0;
            end else if (kill_addr >= 0 && buf_we && int'(buf_addr) == kill_addr) begin
               bus_ack = 1'b0;
               killed  = 1'b1;
            end else begin
               if (ack_cnt < 3) ack_cnt++;
               if (ack_cnt == 3) bus_ack = 1'b1;
            end
            ack_w = bus_req_w;
         end
      end
   end

   always @(posedge clk) begin
      if (cen) begin
         ram_dout <= ram_f(blcnten ? obj_ab : 13'h0000);
         ram_w    <= ram_f(blcnten_w ? obj_ab_w : 13'h0000);
      end
   end

   always @(negedge clk) begin
      if (cen) begin
         if (buf_we) begin
            if (wr_cnt == 0) first_addr = int'(buf_addr);
            wr_cnt++;
            last_addr = int'(buf_addr);
            if (sb_q.size() == 0) begin
               check_val("sb_underflow", sb_q.size(), 1);
            end else begin
               exp_v = sb_q.pop_front();
               check_val("wr", {buf_addr, buf_data}, exp_v);
            end
         end
         if (blcnten) en_cnt++;
         if (bus_req) req_cnt++;
         if (bus_req && !req_prev) req_rise++;
         req_prev = bus_req;
         if (done) done_cnt++;
         if (err) err_cnt++;
      end
   end

   always @(negedge clk) begin
      if (cen) begin
         if (blcnten_w) begin
            en_w_cnt++;
            if (abw_q.size() != 0) begin
               exp_ab = abw_q.pop_front();
               check_val("wrap_ab", obj_ab_w, exp_ab);
            end
         end
         if (buf_we_w) begin
            wr_w_cnt++;
            if (sbw_q.size() == 0) begin
               check_val("wrap_sb_underflow", sbw_q.size(), 1);
            end else begin
               exp_w = sbw_q.pop_front();
               check_val("wrap_wr", {buf_addr_w, buf_data_w}, exp_w);
            end
         end
         if (done_w) done_w_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_counts();
      repeat (4) @(posedge clk);
      #2;
      check_val("rst_outs", outs, 36'h0);
      check_val("rst_outs_w", outs_w, 36'h0);
      rst = 1'b0;
      step_cen(3);

      // nominal 512-byte copy
      reset_counts();
      for (int i = 0; i < 512; i++) sb_q.push_back({9'(i), ram_f(13'h1000 + 13'(i))});
      lvbl = 1'b0;
      step_cen(1);
      check_val("trig_req", bus_req, 1);
      for (int k = 0; k < 3000 && done_cnt == 0; k++) step_cen(1);
      step_cen(3);
      check_val("nom_done", done_cnt, 1);
      check_val("nom_wr", wr_cnt, 512);
      check_val("nom_last", last_addr, 511);
      check_val("nom_en", en_cnt, 513);
      check_val("nom_err", err_cnt, 0);
      check_val("nom_req_low", bus_req, 0);
      check_val("nom_busy", busy, 0);
      check_val("nom_sb", sb_q.size(), 0);
      lvbl = 1'b1;
      step_cen(2);

      // ack timeout
      reset_counts();
      ack_hold = 1'b1;
      lvbl = 1'b0;
      for (int k = 0; k < 300 && err_cnt == 0; k++) step_cen(1);
      step_cen(3);
      check_val("to_req_cycles", req_cnt, 63);
      check_val("to_err", err_cnt, 1);
      check_val("to_wr", wr_cnt, 0);
      check_val("to_en", en_cnt, 0);
      check_val("to_done", done_cnt, 0);
      check_val("to_req_low", bus_req, 0);
      ack_hold = 1'b0;
      lvbl = 1'b1;
      step_cen(2);

      // lost ack at write 100
      reset_counts();
      for (int i = 0; i < 100; i++) sb_q.push_back({9'(i), ram_f(13'h1000 + 13'(i))});
      kill_addr = 100;
      lvbl = 1'b0;
      for (int k = 0; k < 2000 && !killed; k++) step_cen(1);
      check_val("lost_kill_seen", killed, 1);
      check_val("lost_en_comb", blcnten, 0);
      check_val("lost_we_comb", buf_we, 0);
      for (int k = 0; k < 50 && err_cnt == 0; k++) step_cen(1);
      step_cen(3);
      check_val("lost_err", err_cnt, 1);
      check_val("lost_done", done_cnt, 0);
      check_val("lost_wr", wr_cnt, 100);
      check_val("lost_last", last_addr, 99);
      check_val("lost_sb", sb_q.size(), 0);
      check_val("lost_idle", busy, 0);
      check_val("lost_req_low", bus_req, 0);
      kill_addr = -1;
      killed = 1'b0;
      lvbl = 1'b1;
      step_cen(2);

      // LVBL re-pulse during COPY is ignored
      reset_counts();
      for (int i = 0; i < 512; i++) sb_q.push_back({9'(i), ram_f(13'h1000 + 13'(i))});
      lvbl = 1'b0;
      for (int k = 0; k < 1000 && wr_cnt < 50; k++) step_cen(1);
      lvbl = 1'b1;
      step_cen(2);
      lvbl = 1'b0;
      for (int k = 0; k < 3000 && done_cnt == 0; k++) step_cen(1);
      step_cen(20);
      check_val("rt_done", done_cnt, 1);
      check_val("rt_wr", wr_cnt, 512);
      check_val("rt_rise", req_rise, 1);
      check_val("rt_sb", sb_q.size(), 0);
      check_val("rt_busy", busy, 0);
      lvbl = 1'b1;
      step_cen(2);

      // reset at write 200
      reset_counts();
      for (int i = 0; i < 200; i++) sb_q.push_back({9'(i), ram_f(13'h1000 + 13'(i))});
      lvbl = 1'b0;
      for (int k = 0; k < 1000 && !(buf_we && buf_addr == 9'd200); k++) step_cen(1);
      check_val("rst_reach200", {buf_we, buf_addr}, {1'b1, 9'd200});
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_val("rst_mid_outs", outs, 36'h0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      check_val("rst_wr", wr_cnt, 200);
      check_val("rst_sb", sb_q.size(), 0);
      reset_counts();
      step_cen(20);
      check_val("rst_no_trig", req_rise, 0);
      check_val("rst_idle", outs, 36'h0);
      lvbl = 1'b1;
      step_cen(2);
      reset_counts();
      for (int i = 0; i < 512; i++) sb_q.push_back({9'(i), ram_f(13'h1000 + 13'(i))});
      lvbl = 1'b0;
      for (int k = 0; k < 3000 && done_cnt == 0; k++) step_cen(1);
      step_cen(3);
      check_val("re_done", done_cnt, 1);
      check_val("re_first", first_addr, 0);
      check_val("re_wr", wr_cnt, 512);
      check_val("re_sb", sb_q.size(), 0);
      lvbl = 1'b1;
      step_cen(2);

      // 4-byte copy wrapping past the top of RAM
      reset_counts();
      abw_q.push_back(13'h1FFE);
      abw_q.push_back(13'h1FFF);
      abw_q.push_back(13'h0000);
      abw_q.push_back(13'h0001);
      for (int i = 0; i < 4; i++) sbw_q.push_back({9'(i), ram_f(13'h1FFE + 13'(i))});
      lvbl_w = 1'b0;
      for (int k = 0; k < 100 && done_w_cnt == 0; k++) step_cen(1);
      step_cen(3);
      check_val("wrap_done", done_w_cnt, 1);
      check_val("wrap_wr_cnt", wr_w_cnt, 4);
      check_val("wrap_en_cnt", en_w_cnt, 5);
      check_val("wrap_ab_left", abw_q.size(), 0);
      check_val("wrap_sb_left", sbw_q.size(), 0);
      check_val("wrap_idle", outs_w, 36'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
